// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer
// Frame-level controller that streams one ImageWidth x ImageWidth image from a
// single-port pixel buffer into the conv/pooling pipeline. It then drains the
// pipeline with FlushCycles accepted empty beats, counts output beats, and
// pulses done.
// Optional feature: define CFS_WATCHDOG_EN to build a FLUSH timeout. On timeout
// the block raises a sticky error and ends the frame. Without the macro, error
// is tied low and FLUSH waits indefinitely.

module conv_frame_sequencer #(
  parameter int BitSize       = 8,
  parameter int ImageWidth    = 8,
  parameter int NumberOfK     = 8,
  parameter int FlushCycles   = 448,
  parameter int ExpectedBeats = 16,
  parameter int AddrWidth     = $clog2(ImageWidth*ImageWidth)
`ifdef CFS_WATCHDOG_EN
  ,
  parameter int WatchdogCycles = 1024
`endif
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 mem_rd_en,
  output logic [AddrWidth-1:0] mem_addr,
  input  logic [BitSize-1:0]   mem_rd_data,
  output logic                 dp_in_valid,
  output logic [BitSize-1:0]   dp_in_data,
  input  logic                 dp_ready,
  input  logic [NumberOfK-1:0] dp_out_valid,
  output logic [15:0]          beat_count
);

  localparam int PixCount = ImageWidth * ImageWidth;
  localparam int PixCntW  = $clog2(PixCount + 1);
  localparam int FlushW   = $clog2(FlushCycles + 1);

  localparam logic [PixCntW-1:0] PixTotal   = PixCntW'(PixCount);
  localparam logic [PixCntW-1:0] PixLast    = PixCntW'(PixCount - 1);
  localparam logic [FlushW-1:0]  FlushMax   = FlushW'(FlushCycles);
  localparam logic [15:0]        BeatTarget = 16'(ExpectedBeats);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } state_t;

  state_t state;

  // Frame bookkeeping
  logic [PixCntW-1:0] req_cnt;
  logic [PixCntW-1:0] pop_cnt;
  logic [FlushW-1:0]  flush_cnt;
  logic [15:0]        beat_q;

  // Two-entry pixel FIFO plus the one-cycle read-in-flight marker
  logic [BitSize-1:0] fifo_mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         fifo_cnt;
  logic               inflight;

  logic               in_stream;
  logic               in_flush;
  logic               pop;
  logic               push;
  logic               rd_issue;
  logic [2:0]         occ_after;
  logic               beat_hit;
  logic [15:0]        beat_next;
  logic [FlushW-1:0]  flush_next;
  logic               flush_exit;
  logic               start_accept;
  logic               wd_expire;

  // Handshake, read-issue and drain-exit decisions for the current cycle
  always_comb begin
    in_stream    = (state == STREAM);
    in_flush     = (state == FLUSH);
    start_accept = (state == IDLE) && start;

    dp_in_valid  = in_stream && (fifo_cnt != 2'd0);
    dp_in_data   = dp_in_valid ? fifo_mem[rd_ptr] : '0;
    pop          = dp_in_valid && dp_ready;
    push         = inflight;

    // A read may issue only if it still fits once this cycle's pop has left
    occ_after    = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
    rd_issue     = in_stream && (req_cnt < PixTotal) && (occ_after < 3'd2);

    beat_hit     = (in_stream || in_flush) && (|dp_out_valid);
    beat_next    = (beat_hit && (beat_q != 16'hFFFF)) ? beat_q + 16'd1 : beat_q;

    flush_next   = (in_flush && dp_ready && (flush_cnt != FlushMax))
                   ? flush_cnt + FlushW'(1) : flush_cnt;
    flush_exit   = in_flush && (flush_next == FlushMax) && (beat_next >= BeatTarget);
  end

  assign busy       = in_stream || in_flush;
  assign done       = (state == DONE);
  assign mem_rd_en  = rd_issue;
  assign mem_addr   = AddrWidth'(req_cnt);
  assign beat_count = beat_q;

`ifdef CFS_WATCHDOG_EN
  localparam int WdW = $clog2(WatchdogCycles + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(WatchdogCycles - 1);

  logic [WdW-1:0] wd_cnt;
  logic           error_q;

  assign wd_expire = in_flush && !flush_exit && (wd_cnt == WdLast);
  assign error     = error_q;

  // Count FLUSH cycles and latch a sticky error on timeout until the next start
  always_ff @(posedge clk) begin
    if (res_n) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else if (start_accept) begin
      wd_cnt  <= '0;
      error_q <= 1'b0;
    end else begin
      if (in_flush && (wd_cnt != WdLast)) begin
        wd_cnt <= wd_cnt + WdW'(1);
      end
      if (wd_expire) begin
        error_q <= 1'b1;
      end
    end
  end
`else
  assign wd_expire = 1'b0;
  assign error     = 1'b0;
`endif

  // Frame FSM: state, request/transfer/flush counters and the output beat count
  always_ff @(posedge clk) begin
    if (res_n) begin
      state     <= IDLE;
      req_cnt   <= '0;
      pop_cnt   <= '0;
      flush_cnt <= '0;
      beat_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= STREAM;
            req_cnt   <= '0;
            pop_cnt   <= '0;
            flush_cnt <= '0;
            beat_q    <= '0;
          end
        end
        STREAM: begin
          beat_q <= beat_next;
          if (rd_issue) begin
            req_cnt <= req_cnt + PixCntW'(1);
          end
          if (pop) begin
            pop_cnt <= pop_cnt + PixCntW'(1);
            if (pop_cnt == PixLast) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          beat_q    <= beat_next;
          flush_cnt <= flush_next;
          if (flush_exit || wd_expire) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy and in-flight tracking; returned data is discarded after reset
  always_ff @(posedge clk) begin
    if (res_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      inflight <= 1'b0;
    end else if (start_accept) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_issue;
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage captures buffer data on the cycle it is valid
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_rd_data;
    end
  end

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb_conv_frame_sequencer
// Directed frame sequence with randomized pixels, backpressure and beat patterns.
// A behavioural model tracks expected addresses, pixel order, flush length and
// beat totals. CFS_WATCHDOG_EN selects the timeout expectations.

module tb_conv_frame_sequencer;

  localparam int BitSize        = 8;
  localparam int ImageWidth     = 8;
  localparam int NumberOfK      = 8;
  localparam int FlushCycles    = 448;
  localparam int ExpectedBeats  = 16;
  localparam int AddrWidth      = $clog2(ImageWidth*ImageWidth);
  localparam int WatchdogCycles = 1024;
  localparam int Pix            = ImageWidth * ImageWidth;
  localparam int CycleLimit     = 3000;
  localparam int HangCycles     = 1100;

  logic                 clk;
  logic                 res_n;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic                 mem_rd_en;
  logic [AddrWidth-1:0] mem_addr;
  logic [BitSize-1:0]   mem_rd_data;
  logic                 dp_in_valid;
  logic [BitSize-1:0]   dp_in_data;
  logic                 dp_ready;
  logic [NumberOfK-1:0] dp_out_valid;
  logic [15:0]          beat_count;

  int checks   = 0;
  int failures = 0;

  logic [BitSize-1:0] pix [Pix];
  logic               lastRdEn;
  int                 lastAddr;

  conv_frame_sequencer #(
    .BitSize       (BitSize),
    .ImageWidth    (ImageWidth),
    .NumberOfK     (NumberOfK),
    .FlushCycles   (FlushCycles),
    .ExpectedBeats (ExpectedBeats),
    .AddrWidth     (AddrWidth)
  ) dut (
    .clk          (clk),
    .res_n        (res_n),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .dp_in_valid  (dp_in_valid),
    .dp_in_data   (dp_in_data),
    .dp_ready     (dp_ready),
    .dp_out_valid (dp_out_valid),
    .beat_count   (beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a failure with tag and both values
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, model the buffer, settle to mid-cycle
  task automatic applyStimulus(input logic rst, input logic st, input logic rdy,
                               input logic [NumberOfK-1:0] ov);
    @(posedge clk);
    #1;
    res_n        = rst;
    start        = st;
    dp_ready     = rdy;
    dp_out_valid = ov;
    mem_rd_data  = lastRdEn ? pix[lastAddr] : BitSize'($urandom);
    @(negedge clk);
    lastRdEn = mem_rd_en;
    lastAddr = int'(mem_addr);
  endtask

  function automatic logic [NumberOfK-1:0] beatPattern(input int n);
    logic [NumberOfK-1:0] v;
    case (n % 4)
      0:       v = NumberOfK'(1);
      1:       v = NumberOfK'(1) << (NumberOfK - 1);
      2:       v = '1;
      default: begin
        v = NumberOfK'($urandom);
        if (v == '0) v = NumberOfK'(3);
      end
    endcase
    return v;
  endfunction

  // Synchronous reset for one cycle, then confirm all outputs idle and no done pulse
  task automatic doReset(input string tag);
    applyStimulus(1'b1, 1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, '1);
    checkOutput({tag, "_busy"},   busy, 0);
    checkOutput({tag, "_done"},   done, 0);
    checkOutput({tag, "_error"},  error, 0);
    checkOutput({tag, "_rd_en"},  mem_rd_en, 0);
    checkOutput({tag, "_addr"},   mem_addr, 0);
    checkOutput({tag, "_valid"},  dp_in_valid, 0);
    checkOutput({tag, "_data"},   dp_in_data, 0);
    checkOutput({tag, "_beats"},  beat_count, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, '1);
      checkOutput({tag, "_no_done"}, done, 0);
      checkOutput({tag, "_idle_beats"}, beat_count, 0);
    end
  endtask

  // Run one frame. mode 0: ready held high; 1: toggle in STREAM, low every 3rd FLUSH cycle;
  // 2: random ready. restartAt: cycle with a start during STREAM. abortAt: pixel count that triggers reset.
  task automatic runFrame(input int mode, input int beats, input int restartAt,
                          input int abortAt, input bit expectTimeout);
    int  xfers, reads, flushReady, flushCyc, hitCycle, modelBeats, given;
    bit  inFlush, prevStall, finished;
    bit  errExp;
    logic rdy, st;
    logic [NumberOfK-1:0] ov;

    xfers = 0; reads = 0; flushReady = 0; flushCyc = 0; hitCycle = 0;
    modelBeats = 0; given = 0; inFlush = 0; prevStall = 0; finished = 0;
    errExp = 1'b0;
`ifdef CFS_WATCHDOG_EN
    errExp = expectTimeout;
`endif
    for (int p = 0; p < Pix; p++) pix[p] = BitSize'($urandom);

    // Start request while IDLE; output beats here must be ignored
    applyStimulus(1'b0, 1'b1, 1'b1, '1);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_done", done, 0);

    for (int idx = 1; idx < CycleLimit && !finished; idx++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = inFlush ? ((flushCyc % 3) != 2) : ((idx % 2) == 1);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      ov = '0;
      if (given < beats && idx >= 2 && ((idx - 2) % 5) == 0) begin
        ov = beatPattern(given);
        given++;
      end
      st = (idx == restartAt);
      applyStimulus(1'b0, st, rdy, ov);

      if (idx == 1) begin
        checkOutput("start_busy", busy, 1);
        checkOutput("start_rd_en", mem_rd_en, 1);
        checkOutput("start_addr", mem_addr, 0);
        checkOutput("start_error_clear", error, 0);
      end
      if (idx == 2) checkOutput("lat_valid_k2", dp_in_valid, 0);
      if (idx == 3) checkOutput("lat_valid_k3", dp_in_valid, 1);

      checkOutput("beat_count", beat_count, modelBeats);
      if (ov != '0) modelBeats++;

      if (done) begin
        checkOutput("done_busy", busy, 0);
        checkOutput("done_pixels", xfers, Pix);
        if (expectTimeout) begin
`ifdef CFS_WATCHDOG_EN
          checkOutput("wd_flush_len", flushCyc, WatchdogCycles);
          checkOutput("wd_error", error, 1);
`else
          checkOutput("hang_no_done", done, 0);
`endif
        end else begin
          checkOutput("flush_len", flushCyc, hitCycle);
          checkOutput("flush_ready_cycles", flushReady, FlushCycles);
          checkOutput("done_error", error, 0);
        end
        finished = 1;
        applyStimulus(1'b0, 1'b0, 1'b1, '1);
        checkOutput("post_done_pulse", done, 0);
        checkOutput("post_busy", busy, 0);
        checkOutput("post_rd_en", mem_rd_en, 0);
        checkOutput("post_valid", dp_in_valid, 0);
        checkOutput("post_beats", beat_count, modelBeats);
        checkOutput("post_error", error, errExp);
        applyStimulus(1'b0, 1'b0, 1'b1, '1);
        checkOutput("idle_beats_hold", beat_count, modelBeats);
        checkOutput("idle_error_hold", error, errExp);
      end else if (!inFlush) begin
        if (mem_rd_en) begin
          checkOutput("rd_addr", mem_addr, reads);
          reads++;
        end
        if (mode == 0 && idx <= Pix) checkOutput("rd_contig", mem_rd_en, 1);
        if (mode == 0 && idx >= 3)   checkOutput("no_bubble", dp_in_valid, 1);
        if (prevStall) checkOutput("valid_hold", dp_in_valid, 1);
        if (dp_in_valid) begin
          checkOutput("pixel_data", dp_in_data, pix[xfers]);
          if (rdy) xfers++;
          prevStall = !rdy;
        end else begin
          prevStall = 0;
        end
        checkOutput("fifo_bound", ((reads - xfers) <= 2), 1);
        if (xfers == Pix) inFlush = 1;
        if (abortAt >= 0 && xfers == abortAt) begin
          doReset("abort");
          finished = 1;
        end
      end else begin
        checkOutput("flush_valid", dp_in_valid, 0);
        checkOutput("flush_data", dp_in_data, 0);
        checkOutput("flush_rd_en", mem_rd_en, 0);
        checkOutput("flush_busy", busy, 1);
        flushCyc++;
        if (rdy) flushReady++;
        if (hitCycle == 0 && flushReady >= FlushCycles && modelBeats >= ExpectedBeats)
          hitCycle = flushCyc;
`ifndef CFS_WATCHDOG_EN
        if (expectTimeout && flushCyc == HangCycles) begin
          checkOutput("hang_busy", busy, 1);
          checkOutput("hang_error", error, 0);
          checkOutput("hang_beats", beat_count, modelBeats);
          doReset("hang_reset");
          finished = 1;
        end
`endif
      end
    end
    checkOutput("frame_finished", finished, 1);
  endtask

  initial begin
    res_n        = 1'b1;
    start        = 1'b0;
    dp_ready     = 1'b0;
    dp_out_valid = '0;
    mem_rd_data  = '0;
    lastRdEn     = 1'b0;
    lastAddr     = 0;
    for (int p = 0; p < Pix; p++) pix[p] = '0;

    $display("[TB] reset");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, '1);
    applyStimulus(1'b0, 1'b0, 1'b0, '1);
    checkOutput("rst_busy",  busy, 0);
    checkOutput("rst_done",  done, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_rd_en", mem_rd_en, 0);
    checkOutput("rst_addr",  mem_addr, 0);
    checkOutput("rst_valid", dp_in_valid, 0);
    checkOutput("rst_data",  dp_in_data, 0);
    checkOutput("rst_beats", beat_count, 0);

    $display("[TB] frame with ready held high");
    runFrame(0, ExpectedBeats, -1, -1, 1'b0);

    $display("[TB] frame with toggling ready");
    runFrame(1, ExpectedBeats, -1, -1, 1'b0);

    $display("[TB] start during STREAM, reset at pixel 30");
    runFrame(0, 4, 20, 30, 1'b0);

    $display("[TB] frame with random ready after abort");
    runFrame(2, 20, -1, -1, 1'b0);

    $display("[TB] frame with too few output beats");
    runFrame(0, 5, -1, -1, 1'b1);

    $display("[TB] normal frame after short-beat frame");
    runFrame(0, ExpectedBeats, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_frame_sequencer.md
Name: conv_frame_sequencer

Overview:
- Frame-level controller that feeds one image into the conv/pooling pipeline (conv_pooling_top) from a single-port pixel buffer.
- Streams ImageWidth*ImageWidth pixels in raster order, honouring the pipeline's ready backpressure.
- Then drives FlushCycles zero-valued, invalid beats to drain the pipeline, counts output beats, and reports frame completion.
- Sits between the host/DMA frame buffer and conv_pooling_top; replaces the bench-style stimulus loop in silicon.

Parameters:
- BitSize, 8, pixel width.
- ImageWidth, 8, image side length; frame = ImageWidth*ImageWidth pixels.
- NumberOfK, 8, width of the pipeline's per-kernel out_valid vector.
- FlushCycles, 448, accepted drain beats issued after the last pixel.
- ExpectedBeats, 16, output beats (cycles with any out_valid bit set) that mark a frame complete.
- AddrWidth, $clog2(ImageWidth*ImageWidth), pixel buffer address width.
- WatchdogCycles, 1024, FLUSH timeout (only with CFS_WATCHDOG_EN).

Ports:
- clk  in  1  clock; one clock domain.
- res_n  in  1  reset; synchronous and active-high (1 = reset), despite the name.
- start  in  1  start-frame request; sampled only in IDLE.
- busy  out  1  high in STREAM and FLUSH.
- done  out  1  one-cycle completion pulse.
- error  out  1  watchdog timeout flag, sticky until next start; constant 0 without the macro.
- mem_rd_en  out  1  pixel buffer read strobe.
- mem_addr  out  AddrWidth  read address.
- mem_rd_data  in  BitSize  read data; valid exactly 1 cycle after mem_rd_en.
- dp_in_valid  out  1  to pipeline in_valid.
- dp_in_data  out  BitSize  to pipeline in_data.
- dp_ready  in  1  pipeline out_ready; a beat transfers when dp_ready=1.
- dp_out_valid  in  NumberOfK  pipeline out_valid vector, monitored only.
- beat_count  out  16  output beats seen this frame; saturates at 16'hFFFF.

Behaviour:
- Reset: all outputs 0; state IDLE; internal buffer emptied; in-flight read data discarded. Reset mid-frame aborts the frame, with no done pulse.
- States and transitions:
  - IDLE -> STREAM when start=1. In the same edge clear beat_count, error, address and counters.
  - STREAM -> FLUSH when the last pixel (index ImageWidth^2-1) transfers.
  - FLUSH -> DONE when flush_cnt == FlushCycles and beat_count >= ExpectedBeats.
  - DONE -> IDLE unconditionally; done=1 only in DONE.
- start in any state other than IDLE is ignored.
- Read side:
  - 2-entry pixel FIFO.
  - Issue a read when pixels_requested < ImageWidth^2 and (occupancy + inflight - pop) < 2.
  - mem_addr increments by 1 per issued read, from 0.
  - Returned data is pushed on the cycle it is valid.
  - No reads in FLUSH, DONE or IDLE.
- Datapath side in STREAM:
  - dp_in_valid = FIFO non-empty; dp_in_data = FIFO head.
  - Pop on dp_in_valid && dp_ready.
  - With dp_ready held at 1: one pixel per cycle, no bubbles after the first.
- Datapath side in FLUSH:
  - dp_in_valid=0, dp_in_data=0.
  - flush_cnt increments only on cycles with dp_ready=1 and saturates at FlushCycles.
- Latency: start sampled at edge k -> mem_rd_en=1 in cycle k+1 -> first dp_in_valid=1 in cycle k+3.
- Beat counting:
  - beat_count increments on every cycle in STREAM or FLUSH where |dp_out_valid=1.
  - Holds its value in DONE and IDLE until the next start.
- Holding rules:
  - dp_ready=0 holds dp_in_valid/dp_in_data stable (valid must not drop).
  - FIFO full blocks new reads.
- Outside STREAM/FLUSH: dp_in_valid=0, mem_rd_en=0.

Optional Feature:
- Macro: CFS_WATCHDOG_EN.
- Defined:
  - A cycle counter runs in FLUSH.
  - If it reaches WatchdogCycles before the FLUSH exit condition: error=1, go to DONE, done pulse.
  - error stays 1 until the next accepted start.
- Undefined: no counter is built; error is tied 0; FLUSH waits indefinitely.

Test Plan:
- Reset + start, dp_ready=1, ImageWidth=8:
  - mem_addr 0..63 on consecutive cycles.
  - First dp_in_valid at k+3; 64 contiguous valid beats carrying buffer contents in order.
- dp_ready toggling 1,0,1,0 during STREAM:
  - Data held stable while dp_ready=0; no pixel lost or duplicated; FIFO never exceeds 2.
- FLUSH with dp_ready low on every 3rd cycle:
  - Exactly 448 dp_ready=1 cycles in FLUSH before DONE.
  - dp_in_valid=0, dp_in_data=0 throughout.
- dp_out_valid pulses 16 times (mixed bit patterns, e.g. 8'h01, 8'h80, 8'hFF):
  - beat_count=16; done pulses for exactly 1 cycle; busy drops in the same cycle; state returns to IDLE.
- start during STREAM, then res_n=1 at pixel 30:
  - Second start ignored.
  - After reset: all outputs 0, no done pulse.
  - A new start restarts from mem_addr 0.
- CFS_WATCHDOG_EN, WatchdogCycles=1024, only 5 output beats:
  - error=1 and done pulse 1024 cycles into FLUSH.
  - error clears on the next start.
